// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_code_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    function automatic int unsigned timeout_cyc(input int unsigned clk_hz,
                                                input int unsigned timeout_us);
        return (clk_hz / 1_000_000) * timeout_us;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches the clock and produces a
// one-cycle pulse on each filtered clock fall.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2k_clk,
    input  logic ps2k_data,
    output logic fall,
    output logic data_s
);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] hist;
    logic [FILTER_LEN-1:0] hist_c;
    logic                  filt;

    assign hist_c = {hist[FILTER_LEN-2:0], clk_sync[1]};

    // Filtered clock only flips after FILTER_LEN identical samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            hist      <= '1;
            filt      <= 1'b1;
            fall      <= 1'b0;
            data_s    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2k_clk};
            data_sync <= {data_sync[0], ps2k_data};
            hist      <= hist_c;
            data_s    <= data_sync[1];
            fall      <= 1'b0;
            if (&hist_c) begin
                filt <= 1'b1;
            end else if (~|hist_c) begin
                filt <= 1'b0;
                fall <= filt;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: deserialises 11-bit frames, checks parity
// and stop bit, folds E0/F0 prefixes into flags and strobes complete codes.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic [7:0] scan_code,
    output logic       is_break,
    output logic       is_ext,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned TIMEOUT_CYC = timeout_cyc(CLK_HZ, TIMEOUT_US);
    localparam int unsigned CNT_W       = cnt_width(TIMEOUT_CYC);

    logic             fall;
    logic             data_s;
    ps2_state_t       state, state_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       shreg, shreg_d;
    logic             par_ok, par_ok_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             brk_pend, brk_pend_d;
    logic             ext_pend, ext_pend_d;
    ps2_code_t        code_q, code_d;
    logic             valid_d;
    logic             err_d;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2k_clk  (ps2k_clk),
        .ps2k_data (ps2k_data),
        .fall      (fall),
        .data_s    (data_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_ok     <= 1'b0;
            cnt        <= '0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            code_q     <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            par_ok     <= par_ok_d;
            cnt        <= cnt_d;
            brk_pend   <= brk_pend_d;
            ext_pend   <= ext_pend_d;
            code_q     <= code_d;
            code_valid <= valid_d;
            frame_err  <= err_d;
        end
    end

    // Frame FSM advances on filtered clock falls; a fall pre-empts timeout.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        par_ok_d   = par_ok;
        cnt_d      = cnt;
        brk_pend_d = brk_pend;
        ext_pend_d = ext_pend;
        code_d     = code_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (fall) begin
            cnt_d = '0;
            case (state)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {data_s, shreg[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = ^{shreg, data_s};
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_s && par_ok) begin
                        if (shreg == PS2_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shreg == PS2_BRK) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            valid_d     = 1'b1;
                            code_d.code = shreg;
                            code_d.brk  = brk_pend;
                            code_d.ext  = ext_pend;
                            brk_pend_d  = 1'b0;
                            ext_pend_d  = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (cnt == CNT_W'(TIMEOUT_CYC)) begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                err_d      = 1'b1;
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

    assign scan_code = code_q.code;
    assign is_break  = code_q.brk;
    assign is_ext    = code_q.ext;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: directed keyboard scenarios plus random frames,
// checked against a byte-level model of prefix folding and error handling.
module tb_ps2_frame_rx;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned TIMEOUT_US = 200;
    localparam int unsigned FILTER_LEN = 8;
    localparam int          TO_CYC     = int'(CLK_HZ / 1_000_000 * TIMEOUT_US);
    localparam int          HALF       = 20;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       ps2k_clk  = 1'b1;
    logic       ps2k_data = 1'b1;
    logic [7:0] scan_code;
    logic       is_break;
    logic       is_ext;
    logic       code_valid;
    logic       frame_err;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    int  got_err   = 0;
    int  exp_err   = 0;
    int  both_seen = 0;
    int  cyc       = 0;
    int  err_cyc   = -1;
    int  last_fall = 0;
    bit  mbrk      = 1'b0;
    bit  mext      = 1'b0;
    int  checks    = 0;
    int  failures  = 0;

    ps2_frame_rx #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2k_clk   (ps2k_clk),
        .ps2k_data  (ps2k_data),
        .scan_code  (scan_code),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (code_valid) got_q.push_back(ev_t'{scan_code, is_break, is_ext});
        if (frame_err) begin
            got_err++;
            err_cyc = cyc;
        end
        if (code_valid && frame_err) both_seen++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Byte-level behaviour: prefixes set flags, codes consume them, errors clear them.
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            mbrk = 1'b0;
            mext = 1'b0;
        end else if (b == 8'hE0) begin
            mext = 1'b1;
        end else if (b == 8'hF0) begin
            mbrk = 1'b1;
        end else begin
            exp_q.push_back(ev_t'{b, mbrk, mext});
            mbrk = 1'b0;
            mext = 1'b0;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Keyboard side: data changes while clock high, device samples on fall.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2k_data = bits[i];
            wait_cyc(HALF);
            ps2k_clk  = 1'b0;
            last_fall = cyc;
            wait_cyc(HALF);
            ps2k_clk  = 1'b1;
            if (i == glitch_at) begin
                wait_cyc(6);
                ps2k_clk = 1'b0;
                wait_cyc(4);
                ps2k_clk = 1'b1;
            end
        end
        ps2k_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input int glitch_at);
        send_bits(frame_bits(b, bad_par), 11, glitch_at);
        model_frame(b, !bad_par);
    endtask

    task automatic check_events(input string tag);
        int n;
        wait_cyc(20);
        chk({tag, ":n_codes"}, 32'(got_q.size()), 32'(exp_q.size()));
        chk({tag, ":n_errs"}, 32'(got_err), 32'(exp_err));
        chk({tag, ":valid_and_err"}, 32'(both_seen), 32'd0);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, ":code_brk_ext"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
        got_err   = 0;
        exp_err   = 0;
        both_seen = 0;
    endtask

    initial begin
        logic [7:0] b;
        bit         bad;
        int         lat;

        wait_cyc(3);
        chk("rst:scan_code", 32'(scan_code), 32'd0);
        chk("rst:is_break", 32'(is_break), 32'd0);
        chk("rst:is_ext", 32'(is_ext), 32'd0);
        chk("rst:code_valid", 32'(code_valid), 32'd0);
        chk("rst:frame_err", 32'(frame_err), 32'd0);
        reset = 1'b1;
        wait_cyc(20);

        send_byte(8'h1C, 1'b0, -1);
        check_events("plain_1c");

        send_byte(8'hF0, 1'b0, -1);
        check_events("after_f0");
        send_byte(8'h1C, 1'b0, -1);
        check_events("break_1c");

        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h75, 1'b0, -1);
        send_byte(8'h1C, 1'b0, -1);
        check_events("ext_break_75");

        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h1C, 1'b1, -1);
        send_byte(8'h1C, 1'b0, -1);
        check_events("bad_parity");

        send_byte(8'hE0, 1'b0, -1);
        send_bits(frame_bits(8'h5A, 1'b0), 6, -1);
        err_cyc = -1;
        wait_cyc(TO_CYC + 60);
        model_frame(8'h00, 1'b0);
        lat = err_cyc - last_fall;
        chk("timeout_latency_window", 32'((lat >= TO_CYC + 5) && (lat <= TO_CYC + 30)), 32'd1);
        send_byte(8'h32, 1'b0, -1);
        check_events("timeout");

        ps2k_data = 1'b0;
        wait_cyc(10);
        ps2k_clk = 1'b0;
        wait_cyc(4);
        ps2k_clk = 1'b1;
        wait_cyc(10);
        ps2k_data = 1'b1;
        wait_cyc(HALF);
        send_byte(8'h1C, 1'b0, -1);
        send_byte(8'h4B, 1'b0, 3);
        check_events("glitch");

        send_byte(8'hF0, 1'b0, -1);
        send_bits(frame_bits(8'h55, 1'b0), 4, -1);
        reset = 1'b0;
        wait_cyc(3);
        chk("midrst:scan_code", 32'(scan_code), 32'd0);
        chk("midrst:is_break", 32'(is_break), 32'd0);
        chk("midrst:code_valid", 32'(code_valid), 32'd0);
        chk("midrst:frame_err", 32'(frame_err), 32'd0);
        mbrk  = 1'b0;
        mext  = 1'b0;
        reset = 1'b1;
        wait_cyc(20);
        send_byte(8'h1C, 1'b0, -1);
        check_events("mid_reset");

        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 4))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            bad = ($urandom_range(0, 5) == 0);
            send_byte(b, bad, -1);
            check_events("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
